// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the mtm_Alu datapath: op codes, error codes, FSM states,
// CRC3 polynomial and status flag positions.
package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam logic [5:0] ERR_DATA = 6'b100100;
    localparam logic [5:0] ERR_CRC  = 6'b010010;
    localparam logic [5:0] ERR_OP   = 6'b001001;

    localparam logic [2:0] CRC3_POLY = 3'b011;
    localparam logic [5:0] CRC_FIRST_IDX = 6'd36;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CRC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Parity bit making the error control byte {1, err, p} carry an even number of ones.
    function automatic logic err_parity(input logic [5:0] err);
        return ^{1'b1, err};
    endfunction

endpackage

// File: rtl/mtm_alu_crc3_serial.sv
// Bit-serial CRC3 (x^3+x+1, init 000), one input bit per shift cycle, MSB first.
module mtm_alu_crc3_serial
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift,
    input  logic       bit_in,
    output logic [2:0] crc
);

    logic [2:0] crc_r;
    logic       fb_s;
    logic [2:0] crc_next_s;

    // Feedback and next-state of the LFSR.
    always_comb begin
        fb_s       = crc_r[2] ^ bit_in;
        crc_next_s = {crc_r[1:0], 1'b0} ^ (fb_s ? CRC3_POLY : 3'b000);
    end

    // CRC register: clear has priority over shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_r <= 3'b000;
        end else if (clear) begin
            crc_r <= 3'b000;
        end else if (shift) begin
            crc_r <= crc_next_s;
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/mtm_alu_core.sv
// Arithmetic stage of the mtm_Alu: latches a request, computes C = B op A with flags,
// appends a serial CRC3 and holds the result frame until the serializer acknowledges it.
module mtm_alu_core
    import mtm_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_to_send,
    input  logic        rdy_to_send_err,
    input  logic [31:0] B_in,
    input  logic [31:0] A_in,
    input  logic [2:0]  op_in,
    input  logic [5:0]  err_flg_in,
    input  logic        out_ack,
    output logic        out_valid,
    output logic        out_is_err,
    output logic [31:0] C_out,
    output logic [7:0]  ctl_out,
    output logic [7:0]  drop_cnt
);

    state_t      state_r;
    logic [31:0] b_r;
    logic [31:0] a_r;
    logic [2:0]  op_r;
    logic [5:0]  err_r;
    logic        is_err_r;
    logic [31:0] c_r;
    logic [3:0]  flags_r;
    logic [5:0]  bit_idx_r;
    logic        out_valid_r;
    logic        out_is_err_r;
    logic [31:0] c_out_r;
    logic [7:0]  ctl_out_r;
    logic [7:0]  drop_cnt_r;

    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic [31:0] res_s;
    logic        carry_s;
    logic        ovf_s;
    logic [3:0]  flags_s;
    logic [36:0] crc_word_s;
    logic        crc_clear_s;
    logic        crc_shift_s;
    logic        crc_bit_s;
    logic [2:0]  crc_s;
    logic        req_any_s;

    assign sum_s  = {1'b0, b_r} + {1'b0, a_r};
    assign diff_s = {1'b0, b_r} - {1'b0, a_r};

    // ALU result and status flags from the latched operands.
    always_comb begin
        res_s   = 32'h0000_0000;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op_r)
            OP_ADD: begin
                res_s   = sum_s[31:0];
                carry_s = sum_s[32];
                ovf_s   = (b_r[31] == a_r[31]) && (sum_s[31] != b_r[31]);
            end
            OP_SUB: begin
                res_s   = diff_s[31:0];
                carry_s = diff_s[32];
                ovf_s   = (b_r[31] != a_r[31]) && (diff_s[31] != b_r[31]);
            end
            OP_AND: begin
                res_s = b_r & a_r;
            end
            OP_OR: begin
                res_s = b_r | a_r;
            end
            default: begin
                res_s = 32'h0000_0000;
            end
        endcase
        flags_s             = 4'b0000;
        flags_s[FLAG_CARRY] = carry_s;
        flags_s[FLAG_OVF]   = ovf_s;
        flags_s[FLAG_ZERO]  = (res_s == 32'h0000_0000);
        flags_s[FLAG_NEG]   = res_s[31];
    end

    // CRC control: cleared while the result is being registered, then fed MSB first.
    always_comb begin
        crc_word_s  = {c_r, 1'b0, flags_r};
        crc_clear_s = (state_r == ST_EXEC);
        crc_shift_s = (state_r == ST_CRC);
        crc_bit_s   = crc_word_s[bit_idx_r];
    end

    mtm_alu_crc3_serial u_crc3 (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear_s),
        .shift  (crc_shift_s),
        .bit_in (crc_bit_s),
        .crc    (crc_s)
    );

    // Request/compute/CRC/hold sequencer with registered output frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            b_r          <= 32'h0000_0000;
            a_r          <= 32'h0000_0000;
            op_r         <= 3'b000;
            err_r        <= 6'b000000;
            is_err_r     <= 1'b0;
            c_r          <= 32'h0000_0000;
            flags_r      <= 4'b0000;
            bit_idx_r    <= 6'd0;
            out_valid_r  <= 1'b0;
            out_is_err_r <= 1'b0;
            c_out_r      <= 32'h0000_0000;
            ctl_out_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rdy_to_send_err) begin
                        err_r    <= err_flg_in;
                        is_err_r <= 1'b1;
                        state_r  <= ST_DONE;
                    end else if (rdy_to_send) begin
                        if (op_is_legal(op_in)) begin
                            b_r      <= B_in;
                            a_r      <= A_in;
                            op_r     <= op_in;
                            is_err_r <= 1'b0;
                            state_r  <= ST_EXEC;
                        end else begin
                            err_r    <= ERR_OP;
                            is_err_r <= 1'b1;
                            state_r  <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    c_r       <= res_s;
                    flags_r   <= flags_s;
                    bit_idx_r <= CRC_FIRST_IDX;
                    state_r   <= ST_CRC;
                end
                ST_CRC: begin
                    if (bit_idx_r == 6'd0) begin
                        state_r <= ST_DONE;
                    end else begin
                        bit_idx_r <= bit_idx_r - 6'd1;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes the frame; ack only counts once it is visible.
                    if (!out_valid_r) begin
                        out_valid_r  <= 1'b1;
                        out_is_err_r <= is_err_r;
                        if (is_err_r) begin
                            c_out_r   <= 32'h0000_0000;
                            ctl_out_r <= {1'b1, err_r, err_parity(err_r)};
                        end else begin
                            c_out_r   <= c_r;
                            ctl_out_r <= {1'b0, flags_r, crc_s};
                        end
                    end else if (out_ack) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_any_s = rdy_to_send | rdy_to_send_err;

    // Saturating count of request pulses that arrive while the stage is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 8'h00;
        end else if (req_any_s && (state_r != ST_IDLE) && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'h01;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_is_err = out_is_err_r;
    assign C_out      = c_out_r;
    assign ctl_out    = ctl_out_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: doc/mtm_alu_core.md
# mtm_alu_core

Arithmetic stage of the mtm_Alu, directly downstream of the deserializer and upstream of the serializer. On a request pulse it latches B, A and the operation, computes C = B op A with four status flags, then computes a serial CRC3 over result and flags. It presents one 32-bit result plus an 8-bit control byte to the serializer and holds them until acknowledged. Error requests bypass arithmetic and produce an error control byte.

## Interface
- No parameters; all widths are fixed by the mtm_Alu protocol.
- clk  in  1  system clock, posedge active
- rst  in  1  one clock; reset is synchronous and active-high
- rdy_to_send  in  1  one-cycle pulse: A_in/B_in/op_in valid, no error
- rdy_to_send_err  in  1  one-cycle pulse: err_flg_in valid
- B_in  in  32  operand B
- A_in  in  32  operand A
- op_in  in  3  AND=000, OR=001, ADD=100, SUB=101
- err_flg_in  in  6  {ERR_DATA, ERR_CRC, ERR_OP} one-hot-duplicated code
- out_ack  in  1  one-cycle pulse from serializer: output consumed
- out_valid  out  1  C_out/ctl_out valid, held until out_ack
- out_is_err  out  1  1 = error frame (C_out not sent)
- C_out  out  32  result
- ctl_out  out  8  data: {0, flags[3:0], crc3[2:0]}; error: {1, err[5:0], parity}
- drop_cnt  out  8  saturating count of requests dropped while busy

## Operation
- States: IDLE, EXEC, CRC, DONE.
- IDLE: rdy_to_send_err -> latch err, go DONE with out_is_err=1. Else rdy_to_send with legal op -> latch operands, go EXEC. rdy_to_send with illegal op -> error frame with err=ERR_OP (6'b001001). Both pulses same cycle: error wins.
- EXEC: register C and flags {carry, overflow, zero, negative}; go CRC, clear CRC reg, bit index 36.
  - ADD: {carry,C} = B + A (33-bit); overflow = signed overflow.
  - SUB: C = B - A; carry = borrow (B < A unsigned); overflow = signed overflow.
  - AND/OR: carry = overflow = 0.
  - zero = (C == 0); negative = C[31].
- CRC: one bit per cycle, MSB first, over 37-bit word {C, 1'b0, flags}. Polynomial x^3+x+1, init 000: fb = crc[2]^bit; crc <= {crc[1], crc[0]^fb, fb}. After 37 bits go DONE.
- DONE: out_valid=1, outputs stable. out_ack -> IDLE, out_valid=0 next cycle.
- Error parity bit: ctl_out[0] chosen so ctl_out has even number of ones.
- Any request pulse outside IDLE is dropped; drop_cnt increments, saturates at 255. out_ack outside DONE ignored.

## Timing
- Reset values: out_valid=0, out_is_err=0, C_out=0, ctl_out=0, drop_cnt=0, state IDLE. Reset mid-operation aborts immediately; no partial output.
- Data request sampled at edge k: EXEC at k+1, CRC k+2..k+38, out_valid high after edge k+39.
- Error request sampled at edge k: out_valid high after edge k+1.
- out_ack sampled at edge m in DONE: out_valid low after m; earliest new request accepted at edge m+1.
- Request on the same edge as out_ack is dropped (counted).

## Structure
- Shared package mtm_alu_pkg: op codes, ERR_DATA/ERR_CRC/ERR_OP constants, state enum, CRC3 polynomial, flag bit positions. The deserializer and serializer use it too.
- One sub-module: mtm_alu_crc3_serial (clk, rst, clear, shift, bit_in, crc[2:0]).

## Test plan
- ADD B=0xFFFFFFFF, A=0x00000001 -> after 39 cycles C_out=0x00000000, ctl_out=0x53 (flags 1010, crc 011), out_is_err=0.
- SUB B=5, A=7 -> C_out=0xFFFFFFFE, flags 1001 (carry, negative), crc matches golden model. AND/OR random vectors with carry=overflow=0.
- rdy_to_send_err with err=6'b100100 -> next cycle out_valid=1, out_is_err=1, ctl_out=0xC9; rdy_to_send with op=3'b010 -> ctl_out=0x93.
- Request during CRC and during DONE -> ignored, drop_cnt=2, in-flight result unchanged. out_ack withheld 100 cycles -> outputs held stable.
- rst asserted mid-CRC -> all outputs 0, next request processed normally with full 39-cycle latency.
- Signed overflow: ADD 0x7FFFFFFF+1 -> overflow=1, negative=1; SUB 0x80000000-1 -> overflow=1, carry=0.
